downsampler_2x2: RTL and testbench
==================================

Name: downsampler_2x2

Overview:
- Streaming 2x2 box-filter decimator for an 8-bit greyscale raster. Converts an IN_WIDTH x IN_HEIGHT frame (default 800x600) to (IN_WIDTH/2) x (IN_HEIGHT/2) (default 400x300).
- Sits on the capture path, ahead of the feature-detection pyramid. It is the inverse of the 2x nearest-neighbour upsampler on the display path.
- Input is a valid-qualified raster with no backpressure. Even rows are pair-summed into a half-width line buffer. Each output pixel is formed on the following odd row.

Parameters:
- IN_WIDTH, 800, input pixels per row; must be even.
- IN_HEIGHT, 600, input rows per frame; must be even.
- DATA_W, 8, pixel width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- valid  in  1  data carries the next raster pixel this cycle
- data  in  DATA_W  input pixel
- dataout  out  DATA_W  averaged output pixel
- validout  out  1  dataout valid this cycle
- eol  out  1  high with validout on the last output pixel of an output row
- frame_done  out  1  one-cycle pulse with the last output pixel of a frame

Behaviour:
- Reset values:
  - colcount=0, rowcount=0, pair register=0.
  - dataout=0, validout=0, eol=0, frame_done=0.
  - Line buffer contents are not cleared. Every entry is rewritten on an even row before it is read.
- Counters:
  - colcount and rowcount are 10 bits; they advance only on valid.
  - When colcount==IN_WIDTH-1 and valid: colcount->0, rowcount+1.
  - When rowcount==IN_HEIGHT-1 and the row wraps: rowcount->0.
- Pairing (applies on every row):
  - Even col: latch data into the pair register p.
  - Odd col: form h = p + data, 9 bits.
- Even row, odd col: write h to the line buffer at address colcount>>1.
- Odd row:
  - Even col: issue a line-buffer read at address colcount>>1.
  - Odd col: s = h + buffered value, 10 bits. Output (s + 2) >> 2, truncated to DATA_W (max 255, no overflow).
- Line-buffer read: 1-cycle latency. The read data register holds its value until the next read enable, so idle cycles between the even-col and odd-col pixels are tolerated.
- Output latency: validout is asserted exactly 1 clock after the odd-row, odd-col input pixel is accepted. It is high for 1 cycle and never asserted otherwise.
- eol: high when the producing input col == IN_WIDTH-1.
- frame_done: high when eol is high and the producing row == IN_HEIGHT-1.
- Back-to-back valid: sustained at 1 pixel/clock, no stalls. Output rate is 1 per 2 clocks on odd rows and 0 on even rows.
- Simultaneous events:
  - A read and a write never target the buffer in the same cycle. Reads occur only on odd rows and writes only on even rows.
  - The counter wrap and the output for the last pixel occur in the same cycle. The output uses the pre-wrap coordinates.
- Reset mid-frame:
  - All in-flight state is discarded and validout drops to 0 on the next cycle.
  - The next accepted pixel is treated as (row 0, col 0).
  - No spurious output is produced from stale buffer contents.
- Missing pixels or a short frame: not detected. The counters define the geometry; upstream guarantees exact frame size.

Decomposition:
- Shared package constants:
  - IN_WIDTH/IN_HEIGHT defaults, also used by the upsampler.
  - Derived OUT_WIDTH=IN_WIDTH/2, OUT_HEIGHT=IN_HEIGHT/2.
  - COUNT_W=10, SUM_W=DATA_W+2.
- Sub-module ds_line_buf: simple dual-port RAM.
  - Depth IN_WIDTH/2, width DATA_W+1.
  - Synchronous write; synchronous read with read enable; registered output.
  - Must infer block RAM.
- Counters, pairing, summation and output registers stay in downsampler_2x2.

Test Plan:
- Constant frame, all pixels 100, continuous valid -> exactly 120000 validout pulses, all dataout=100, 300 eol pulses, one frame_done coincident with the final output.
- Top-left block (r0c0=10, r0c1=20, r1c0=30, r1c1=41) -> first output = (101+2)>>2 = 25, one clock after r1c1 is accepted.
- Rounding checks:
  - Block 1,1,1,2 -> 1.
  - Block 1,1,2,2 -> 2.
  - Block 0,0,0,1 -> 0.
  - Block 255 x4 -> 255.
- Random idle gaps (valid low for 0-5 cycles between pixels, including between the even-col and odd-col pixels on odd rows) -> output sequence identical to the gap-free run; each validout exactly 1 cycle after its odd/odd pixel.
- Ramp frame, data = (col+row) mod 256, two consecutive frames -> outputs match the golden model for both frames; counters wrap cleanly and frame_done fires twice.
- Reset asserted after 1000 pixels of frame 1, then a full frame of value 77 -> no validout during or immediately after reset; exactly 120000 outputs, all 77.

Source files
------------

// File: rtl/downsampler_2x2_pkg.sv
// Shared geometry and width constants for the 2x2 resampler pair
// (this decimator on the capture path, the nearest-neighbour upsampler on display).
package downsampler_2x2_pkg;

  localparam int DEFAULT_IN_WIDTH  = 800;
  localparam int DEFAULT_IN_HEIGHT = 600;
  localparam int DEFAULT_DATA_W    = 8;

  localparam int OUT_WIDTH  = DEFAULT_IN_WIDTH / 2;
  localparam int OUT_HEIGHT = DEFAULT_IN_HEIGHT / 2;

  // Raster counters are sized for 800x600; SUM_W holds a full 2x2 box sum.
  localparam int COUNT_W = 10;
  localparam int SUM_W   = DEFAULT_DATA_W + 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ds_line_buf.sv
// Half-width line buffer holding the horizontal pair sums of the last even row.
// Simple dual-port, registered read with enable so it maps onto block RAM.
module ds_line_buf
  import downsampler_2x2_pkg::*;
#(
  parameter int DEPTH  = OUT_WIDTH,
  parameter int WIDTH  = DEFAULT_DATA_W + 1,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // No reset on the read register: it only ever feeds odd rows, whose entries
  // were rewritten on the preceding even row.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/downsampler_2x2.sv
// Streaming 2x2 box-filter decimator: even rows are pair-summed into a line buffer,
// odd rows complete each box and emit the rounded average one clock later.
module downsampler_2x2
  import downsampler_2x2_pkg::*;
#(
  parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int IN_HEIGHT = DEFAULT_IN_HEIGHT,
  parameter int DATA_W    = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  output logic              eol,
  output logic              frame_done
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int ADDR_W = addr_width(HALF_W);
  localparam int PAIR_W = DATA_W + 1;
  localparam int BOX_W  = DATA_W + 2;

  logic [COUNT_W-1:0] colcount;
  logic [COUNT_W-1:0] rowcount;
  logic [DATA_W-1:0]  pair_reg;
  logic               col_last;
  logic               row_last;
  logic               odd_col;
  logic               odd_row;
  logic [PAIR_W-1:0]  h_sum;
  logic [PAIR_W-1:0]  buf_rd_data;
  logic [BOX_W-1:0]   box_sum;
  logic [BOX_W-1:0]   box_round;
  logic [ADDR_W-1:0]  buf_addr;
  logic               buf_wr_en;
  logic               buf_rd_en;
  logic               produce;

  assign col_last = (colcount == COUNT_W'(IN_WIDTH - 1));
  assign row_last = (rowcount == COUNT_W'(IN_HEIGHT - 1));
  assign odd_col  = colcount[0];
  assign odd_row  = rowcount[0];
  assign buf_addr = colcount[ADDR_W:1];

  assign h_sum     = PAIR_W'(pair_reg) + PAIR_W'(data);
  assign box_sum   = BOX_W'(h_sum) + BOX_W'(buf_rd_data);
  assign box_round = box_sum + BOX_W'(2);

  assign buf_wr_en = valid && !odd_row && odd_col;
  assign buf_rd_en = valid && odd_row && !odd_col;
  assign produce   = valid && odd_row && odd_col;

  // The raster position is defined purely by counting accepted pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      colcount <= '0;
      rowcount <= '0;
    end else if (valid) begin
      if (col_last) begin
        colcount <= '0;
        rowcount <= row_last ? '0 : rowcount + COUNT_W'(1);
      end else begin
        colcount <= colcount + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pair_reg <= '0;
    end else if (valid && !odd_col) begin
      pair_reg <= data;
    end
  end

  // Outputs use the coordinates of the producing pixel, before any counter wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataout    <= '0;
      validout   <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      validout   <= produce;
      eol        <= produce && col_last;
      frame_done <= produce && col_last && row_last;
      if (produce) begin
        dataout <= box_round[BOX_W-1:2];
      end
    end
  end

  ds_line_buf #(
    .DEPTH  (HALF_W),
    .WIDTH  (PAIR_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_addr (buf_addr),
    .wr_data (h_sum),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_addr),
    .rd_data (buf_rd_data)
  );

endmodule

// File: tb/tb_downsampler_2x2.sv
// Self-checking bench for downsampler_2x2 on a reduced 20x8 raster, with a
// frame-level 2x2 box-average model checked against the outputs every cycle.
module tb_downsampler_2x2;

  localparam int W    = 20;
  localparam int H    = 8;
  localparam int DW   = 8;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clock = 1'b0;
  logic          reset;
  logic          valid;
  logic [DW-1:0] data;
  logic [DW-1:0] dataout;
  logic          validout;
  logic          eol;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  int img [H][W];

  logic exp_valid = 1'b0;
  int   exp_data  = 0;
  logic exp_eol   = 1'b0;
  logic exp_fd    = 1'b0;

  int cnt_valid = 0;
  int cnt_eol   = 0;
  int cnt_fd    = 0;
  int cap[$];
  int ref_q[$];

  downsampler_2x2 #(
    .IN_WIDTH  (W),
    .IN_HEIGHT (H),
    .DATA_W    (DW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .data       (data),
    .dataout    (dataout),
    .validout   (validout),
    .eol        (eol),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  function automatic int box(input int a, input int b, input int c, input int d);
    return (a + b + c + d + 2) / 4;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle: outputs must match what the model predicted for the pixel
  // accepted on the previous edge, and must be quiet otherwise.
  always @(posedge clock) begin
    #1;
    checkOutput("validout", int'(validout), int'(exp_valid));
    checkOutput("eol", int'(eol), int'(exp_valid && exp_eol));
    checkOutput("frame_done", int'(frame_done), int'(exp_valid && exp_fd));
    if (exp_valid) begin
      checkOutput("dataout", int'(dataout), exp_data);
    end
    if (validout) begin
      cnt_valid++;
      cap.push_back(int'(dataout));
    end
    if (eol) cnt_eol++;
    if (frame_done) cnt_fd++;
  end

  task automatic applyStimulus(input logic rst, input logic v, input int value,
                               input logic ev, input int ed, input logic ee, input logic ef);
    @(negedge clock);
    reset     = rst;
    valid     = v;
    data      = DW'(value);
    exp_valid = ev;
    exp_data  = ed;
    exp_eol   = ee;
    exp_fd    = ef;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic sendPixel(input int r, input int c);
    logic ev;
    int   ed;
    ev = (r % 2 == 1) && (c % 2 == 1);
    ed = ev ? box(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]) : 0;
    applyStimulus(1'b0, 1'b1, img[r][c], ev, ed, c == W - 1, (c == W - 1) && (r == H - 1));
  endtask

  // Drives one frame from img; stop_after >= 0 truncates it after that many pixels.
  task automatic runFrame(input int max_gap, input int stop_after);
    int n;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n == stop_after) return;
        if (max_gap > 0) idle($urandom_range(max_gap, 0));
        sendPixel(r, c);
        n++;
      end
    end
  endtask

  task automatic fillConst(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = v;
  endtask

  task automatic fillRamp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c + r) % 256;
  endtask

  task automatic setBlock(input int k, input int a, input int b, input int c, input int d);
    img[0][2*k] = a; img[0][2*k+1] = b; img[1][2*k] = c; img[1][2*k+1] = d;
  endtask

  task automatic clearCounts();
    cnt_valid = 0;
    cnt_eol   = 0;
    cnt_fd    = 0;
    cap.delete();
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    data  = '0;
    doReset(3);
    idle(1);
    checkOutput("reset_dataout", int'(dataout), 0);
    checkOutput("reset_validout", int'(validout), 0);
    checkOutput("reset_eol", int'(eol), 0);
    checkOutput("reset_frame_done", int'(frame_done), 0);

    $display("[TB] constant frame of 100");
    fillConst(100);
    clearCounts();
    runFrame(0, -1);
    idle(3);
    checkOutput("const_count", cnt_valid, NOUT);
    checkOutput("const_eol_count", cnt_eol, H / 2);
    checkOutput("const_fd_count", cnt_fd, 1);
    checkOutput("const_first", cap.size() > 0 ? cap[0] : -1, 100);

    $display("[TB] rounding blocks");
    fillRamp();
    setBlock(0, 10, 20, 30, 41);
    setBlock(1, 1, 1, 1, 2);
    setBlock(2, 1, 1, 2, 2);
    setBlock(3, 0, 0, 0, 1);
    setBlock(4, 255, 255, 255, 255);
    checkOutput("model_topleft", box(10, 20, 30, 41), 25);
    checkOutput("model_round_1112", box(1, 1, 1, 2), 1);
    checkOutput("model_round_1122", box(1, 1, 2, 2), 2);
    checkOutput("model_round_0001", box(0, 0, 0, 1), 0);
    checkOutput("model_round_255", box(255, 255, 255, 255), 255);
    clearCounts();
    runFrame(0, -1);
    idle(3);
    checkOutput("blk_count", cap.size(), NOUT);
    checkOutput("blk_topleft", cap.size() > 0 ? cap[0] : -1, 25);
    checkOutput("blk_1112", cap.size() > 1 ? cap[1] : -1, 1);
    checkOutput("blk_1122", cap.size() > 2 ? cap[2] : -1, 2);
    checkOutput("blk_0001", cap.size() > 3 ? cap[3] : -1, 0);
    checkOutput("blk_255", cap.size() > 4 ? cap[4] : -1, 255);

    $display("[TB] ramp, two frames back to back");
    fillRamp();
    clearCounts();
    runFrame(0, -1);
    runFrame(0, -1);
    idle(3);
    checkOutput("ramp_count", cnt_valid, 2 * NOUT);
    checkOutput("ramp_fd_count", cnt_fd, 2);
    checkOutput("ramp_eol_count", cnt_eol, H);
    checkOutput("ramp_first", cap.size() > 0 ? cap[0] : -1, box(0, 1, 1, 2));
    ref_q = cap;

    $display("[TB] ramp with idle gaps");
    clearCounts();
    runFrame(5, -1);
    runFrame(5, -1);
    idle(3);
    checkOutput("gap_count", cap.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < cap.size(); i++) begin
      if (cap[i] != ref_q[i]) checkOutput($sformatf("gap_seq[%0d]", i), cap[i], ref_q[i]);
    end
    checkOutput("gap_fd_count", cnt_fd, 2);

    $display("[TB] reset mid-frame, then frame of 77");
    fillRamp();
    runFrame(0, 70);
    doReset(2);
    idle(2);
    clearCounts();
    fillConst(77);
    runFrame(1, -1);
    idle(3);
    checkOutput("post_reset_count", cnt_valid, NOUT);
    checkOutput("post_reset_fd", cnt_fd, 1);
    checkOutput("post_reset_last", cap.size() > 0 ? cap[cap.size()-1] : -1, 77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
